// File: rtl/multi_ff_bank.sv
// Bank of WIDTH single-bit flip-flops switchable per cycle between SR, JK, D and T behaviour,
// with illegal-SR detection. Define MULTI_FF_LOAD_EN to add a parallel load port (i_load/i_load_val).
module multi_ff_bank #(
    parameter int                WIDTH     = 8,
    parameter int                CNT_W     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,          // active-low, asynchronous
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_clr_err,
`ifdef MULTI_FF_LOAD_EN
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_load_val,
`endif
    output logic [WIDTH-1:0]     o_q,
    output logic [WIDTH-1:0]     o_q_bar,
    output logic [WIDTH-1:0]     o_changed,
    output logic                 o_illegal,
    output logic                 o_illegal_sticky,
    output logic [CNT_W-1:0]     o_illegal_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_changed;
    logic             r_illegal;
    logic             r_illegal_sticky;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic [WIDTH-1:0] w_ch_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_illegal_evt;

`ifdef MULTI_FF_LOAD_EN
    assign w_load     = i_load;
    assign w_load_val = i_load_val;
`else
    assign w_load     = 1'b0;
    assign w_load_val = '0;
`endif

    // Per-channel next state; an SR channel with S=R=1 simply holds.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_ch
            logic w_set;
            logic w_clr;
            logic w_both;
            assign w_set  = i_a[gi] & ~i_b[gi];
            assign w_clr  = ~i_a[gi] & i_b[gi];
            assign w_both = i_a[gi] & i_b[gi];

            assign w_ch_next[gi] =
                (i_mode == MODE_SR) ? (w_set ? 1'b1 : (w_clr ? 1'b0 : r_q[gi])) :
                (i_mode == MODE_JK) ? (w_both ? ~r_q[gi] :
                                      (w_set ? 1'b1 : (w_clr ? 1'b0 : r_q[gi]))) :
                (i_mode == MODE_D)  ? i_a[gi] :
                                      (r_q[gi] ^ i_a[gi]);
        end
    endgenerate

    assign w_q_next      = w_load ? w_load_val : (i_en ? w_ch_next : r_q);
    assign w_illegal_evt = ~w_load & i_en & (i_mode == MODE_SR) & (|(i_a & i_b));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q              <= RESET_VAL;
            r_changed        <= '0;
            r_illegal        <= 1'b0;
            r_illegal_sticky <= 1'b0;
            r_illegal_cnt    <= '0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_next ^ r_q;
            r_illegal <= w_illegal_evt;
            // An illegal event beats a simultaneous clear: count restarts at one.
            if (w_illegal_evt) begin
                r_illegal_sticky <= 1'b1;
                if (i_clr_err) begin
                    r_illegal_cnt <= CNT_ONE;
                end else if (!(&r_illegal_cnt)) begin
                    r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
                end
            end else if (i_clr_err) begin
                r_illegal_sticky <= 1'b0;
                r_illegal_cnt    <= '0;
            end
        end
    end

    assign o_q              = r_q;
    assign o_q_bar          = ~r_q;
    assign o_changed        = r_changed;
    assign o_illegal        = r_illegal;
    assign o_illegal_sticky = r_illegal_sticky;
    assign o_illegal_cnt    = r_illegal_cnt;

endmodule

// File: tb/tb_multi_ff_bank.sv
// Scoreboard bench for multi_ff_bank: driver pushes model predictions, monitor pops and compares.
module tb_multi_ff_bank;

    localparam logic [1:0] SR = 2'b00;
    localparam logic [1:0] JK = 2'b01;
    localparam logic [1:0] DM = 2'b10;
    localparam logic [1:0] TM = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] q, q_bar, changed, cnt;
    logic       illegal, sticky;

    typedef struct {
        logic [7:0] q;
        logic [7:0] ch;
        logic       il;
        logic       st;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    int n_txn = 0;

    // reference model state
    logic [7:0] m_q = 8'h00;
    logic       m_st = 1'b0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    multi_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_en(en),
        .i_mode(mode),
        .i_a(a),
        .i_b(b),
        .i_clr_err(clr),
`ifdef MULTI_FF_LOAD_EN
        .i_load(load),
        .i_load_val(load_val),
`endif
        .o_q(q),
        .o_q_bar(q_bar),
        .o_changed(changed),
        .o_illegal(illegal),
        .o_illegal_sticky(sticky),
        .o_illegal_cnt(cnt)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bank transaction: drive inputs at the falling edge, predict the result of the next rising edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] ia, input logic [7:0] ib, input logic c,
                        input logic ld, input logic [7:0] lv);
        exp_t       x;
        logic [7:0] nq;
        logic       conf;
        logic       use_ld;
        @(negedge clk);
        rst_n = r; en = e; mode = m; a = ia; b = ib; clr = c; load = ld; load_val = lv;
`ifdef MULTI_FF_LOAD_EN
        use_ld = ld;
`else
        use_ld = 1'b0;
`endif
        if (!r) begin
            m_q = 8'h00; m_st = 1'b0; m_cnt = 0;
            x.q = 8'h00; x.ch = 8'h00; x.il = 1'b0; x.st = 1'b0; x.cnt = 8'h00;
        end else begin
            nq = m_q;
            conf = 1'b0;
            if (use_ld) begin
                nq = lv;
            end else if (e) begin
                for (int i = 0; i < 8; i++) begin
                    case (m)
                        SR: begin
                            if (ia[i] && ib[i]) conf = 1'b1;
                            else if (ia[i]) nq[i] = 1'b1;
                            else if (ib[i]) nq[i] = 1'b0;
                        end
                        JK: begin
                            if (ia[i] && ib[i]) nq[i] = ~m_q[i];
                            else if (ia[i]) nq[i] = 1'b1;
                            else if (ib[i]) nq[i] = 1'b0;
                        end
                        DM: nq[i] = ia[i];
                        default: if (ia[i]) nq[i] = ~m_q[i];
                    endcase
                end
            end
            if (conf) begin
                m_st = 1'b1;
                m_cnt = c ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (c) begin
                m_st = 1'b0;
                m_cnt = 0;
            end
            x.q = nq; x.ch = nq ^ m_q; x.il = conf; x.st = m_st; x.cnt = 8'(m_cnt);
            m_q = nq;
        end
        sb.push_back(x);
    endtask

    // Reset must act mid-cycle, without waiting for a clock edge.
    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_q", q, 8'h00);
        chk("async_qbar", q_bar, 8'hFF);
        chk("async_changed", changed, 8'h00);
        chk("async_illegal", {7'b0, illegal}, 8'h00);
        chk("async_sticky", {7'b0, sticky}, 8'h00);
        chk("async_cnt", cnt, 8'h00);
        m_q = 8'h00; m_st = 1'b0; m_cnt = 0;
    endtask

    // Monitor: every rising edge presents a new registered result.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_txn++;
                chk("q", q, x.q);
                chk("q_bar", q_bar, ~x.q);
                chk("changed", changed, x.ch);
                chk("illegal", {7'b0, illegal}, {7'b0, x.il});
                chk("sticky", {7'b0, sticky}, {7'b0, x.st});
                chk("cnt", cnt, x.cnt);
                $display("txn %0d: q=%h changed=%h illegal=%b sticky=%b cnt=%h",
                         n_txn, q, changed, illegal, sticky, cnt);
            end
        end
    end

    initial begin
        // reset held low with set-inputs applied, then release
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SR, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);

        // SR with partial conflict
        step(1'b1, 1'b1, DM, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // JK toggle
        step(1'b1, 1'b1, DM, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, JK, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, JK, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00);

        // D, T, then hold with en=0
        step(1'b1, 1'b1, DM, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, TM, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, TM, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, TM, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h00);

        // counter saturation, clear, clear-vs-event
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, SR, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, SR, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, SR, 8'h80, 8'h80, 1'b1, 1'b0, 8'h00);

        // asynchronous reset mid-cycle
        step(1'b1, 1'b1, DM, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00);
        async_reset_check();
        step(1'b0, 1'b1, DM, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, DM, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

`ifdef MULTI_FF_LOAD_EN
        step(1'b1, 1'b0, SR, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h5A);
        step(1'b1, 1'b1, DM, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, SR, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h5A);
        step(1'b1, 1'b1, DM, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(7) != 0), 2'($urandom_range(3)),
                 8'($urandom), 8'($urandom), ($urandom_range(7) == 0),
                 ($urandom_range(7) == 0), 8'($urandom));
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_ff_bank.md
Name: multi_ff_bank

Overview:
- Parametrised bank of WIDTH independent single-bit flip-flops sharing one clock, one reset and one mode select.
- Each cycle the bank behaves as SR, JK, D or T flip-flops, selected by `mode`.
- Illegal SR input combinations are detected, reported as a pulse, a sticky flag and a saturating count.
- Generalised successor to the single SR flip-flop; used as a general state-bit bank in control logic.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- CNT_W, 8, width of the illegal-event counter.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  bank update enable; q holds when 0.
- mode  input  2  00=SR, 01=JK, 10=D, 11=T; sampled each clock edge.
- a  input  WIDTH  per channel: S (SR), J (JK), D (D), T (T).
- b  input  WIDTH  per channel: R (SR), K (JK); ignored in D and T modes.
- clr_err  input  1  synchronous clear of illegal_sticky and illegal_cnt.
- q  output  WIDTH  flip-flop state.
- q_bar  output  WIDTH  always ~q, including during reset.
- changed  output  WIDTH  registered mask of bits that changed at the last edge.
- illegal  output  1  registered pulse; set for one cycle after an edge where en=1, mode=SR and any channel had a=b=1.
- illegal_sticky  output  1  set by an illegal event; held until clr_err or reset.
- illegal_cnt  output  CNT_W  count of illegal edges, saturating at all-ones.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - q=RESET_VAL, q_bar=~RESET_VAL.
  - changed=0, illegal=0, illegal_sticky=0, illegal_cnt=0.
- Deassertion is sampled at the next rising edge; no update occurs on the edge at which reset is still low.
- Latency: one clock; all outputs are registered except q_bar, which is the combinational inverse of q.
- en=0: q holds, changed=0, illegal=0; sticky and count hold, but clr_err still acts.
- Per-channel next state with en=1:
  - SR: 00 hold, 10 set, 01 clear, 11 hold and flag illegal. The channel holds; other channels update normally.
  - JK: 00 hold, 10 set, 01 clear, 11 toggle. Never illegal.
  - D: q=a.
  - T: a=1 toggle, a=0 hold.
- Mode changes take effect on the same edge they are sampled; there is no pipeline and no settling cycle.
- changed = q_next ^ q_current, registered alongside q.
- Illegal event:
  - illegal = en & (mode==SR) & |(a & b), registered.
  - illegal_cnt increments by 1 per illegal edge, regardless of how many channels conflict, and saturates at 2^CNT_W-1 with no wrap.
- clr_err with an illegal event on the same edge: the event wins. illegal_sticky=1 and illegal_cnt=1, with the count cleared then incremented.
- clr_err alone: illegal_sticky=0, illegal_cnt=0; q is unaffected.
- Reset asserted mid-operation overrides everything immediately; there are no partial updates.

Optional Feature:
- Macro: MULTI_FF_LOAD_EN.
- When defined:
  - Adds ports `load` (input, 1) and `load_val` (input, WIDTH).
  - load=1 at an edge sets q=load_val regardless of en and mode, suppresses illegal detection for that edge, and computes changed against load_val.
  - Priority: reset > load > en.
- When undefined: the ports do not exist and behaviour is exactly as above.

Test Plan (WIDTH=8, CNT_W=8, RESET_VAL=0):
- Reset: hold reset=0 with a=FF, b=00, en=1, mode=SR, then release. While reset is low, q=00, q_bar=FF. At the first edge after release, q=FF and changed=FF; at the next edge, changed=00.
- SR with conflict: q=0F, then mode=SR, a=F0, b=3C, en=1. Result q=C3 (bits 5:4 hold at 0), illegal=1 for one cycle, illegal_sticky=1, illegal_cnt=1.
- JK toggle: q=AA, then mode=JK, a=FF, b=FF for 2 edges. q goes 55 then AA, illegal stays 0, and changed=FF on both edges.
- D and T: mode=D, a=3C gives q=3C. Then mode=T, a=0F gives q=33, then 3C. Setting en=0 afterwards holds q=3C with changed=00.
- Counter saturation and clear:
  - Hold an SR conflict for 300 edges; illegal_cnt stops at FF.
  - clr_err with no conflict gives sticky=0, cnt=00.
  - clr_err together with a conflict gives sticky=1, cnt=01.
- MULTI_FF_LOAD_EN build: with q=00, drive load=1, load_val=5A, en=0, mode=SR, a=b=FF. Result q=5A, illegal=0, changed=5A. Asserting reset low on the same cycle as load instead gives q=00.
